ps2_host_tx: RTL and testbench

- Host-to-device PS/2 transmitter. It is the outbound counterpart of the PS/2 keyboard receive path.
- Sends one command byte to the keyboard, for example 0xED (set LEDs), 0xFF (reset) or 0xF3 (typematic).
- Drives the open-drain ps2_clk and ps2_data lines through enable outputs.
- Runs the full request-to-send sequence, tracks the device-generated clock, checks the device ACK and reports done or error to the CPU-side keyboard controller.
- Holds rx_inhibit while it owns the bus so the receiver ignores the exchange.

---
 rtl/ps2_pkg.sv | 34 +++
 rtl/ps2_line_sync.sv | 36 +++
 rtl/ps2_host_tx.sv | 193 +++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter states, frame layout and common
// keyboard command bytes.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    WAIT_FIRST,
    DATA,
    PARITY,
    ACK,
    WAIT_IDLE,
    ABORT
  } ps2_state_t;

  localparam int DATA_BITS       = 8;
  localparam int FALLS_PER_FRAME = 11;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ECHO     = 8'hEE;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Odd parity: data bits plus parity bit carry an odd number of ones.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Synchronizes the PS/2 clock and data lines into clk and flags each falling
// edge of the synchronized clock with a one-cycle pulse.
module ps2_line_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic clrn,
  input  logic line_clk,
  input  logic line_data,
  output logic sync_clk,
  output logic sync_data,
  output logic fall
);

  logic [STAGES-1:0] clk_sr;
  logic [STAGES-1:0] data_sr;
  logic              clk_prev;

  // Flops reset to the idle-high bus level so reset release never fakes an edge.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_sr   <= '1;
      data_sr  <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sr   <= {clk_sr[STAGES-2:0], line_clk};
      data_sr  <= {data_sr[STAGES-2:0], line_data};
      clk_prev <= clk_sr[STAGES-1];
    end
  end

  assign sync_clk  = clk_sr[STAGES-1];
  assign sync_data = data_sr[STAGES-1];
  assign fall      = clk_prev & ~clk_sr[STAGES-1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, bit shifting on device
// clock falls, ACK check and done/timeout reporting to the controller.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int START_TIMEOUT  = 750000,
  parameter int XFER_TIMEOUT   = 100000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic       wr,
  input  logic [7:0] din,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       timeout,
  output logic       rx_inhibit
);

  localparam int CW = $clog2(max3(INHIBIT_CYCLES, START_TIMEOUT, XFER_TIMEOUT) + 1);

  ps2_state_t state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [3:0]    idx_reg, idx_next;
  logic [7:0]    shift_reg, shift_next;
  logic          parity_reg, parity_next;
  logic          clk_oe_reg, clk_oe_next;
  logic          data_oe_reg, data_oe_next;
  logic          busy_reg, busy_next;
  logic          done_reg, done_next;
  logic          ack_ok_reg, ack_ok_next;
  logic          timeout_reg, timeout_next;
  logic          ack_sample_reg, ack_sample_next;

  logic sync_clk, sync_data, fall;

  ps2_line_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .clrn      (clrn),
    .line_clk  (ps2_clk),
    .line_data (ps2_data),
    .sync_clk  (sync_clk),
    .sync_data (sync_data),
    .fall      (fall)
  );

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      idx_reg        <= '0;
      shift_reg      <= '0;
      parity_reg     <= 1'b0;
      clk_oe_reg     <= 1'b0;
      data_oe_reg    <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      ack_ok_reg     <= 1'b0;
      timeout_reg    <= 1'b0;
      ack_sample_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      idx_reg        <= idx_next;
      shift_reg      <= shift_next;
      parity_reg     <= parity_next;
      clk_oe_reg     <= clk_oe_next;
      data_oe_reg    <= data_oe_next;
      busy_reg       <= busy_next;
      done_reg       <= done_next;
      ack_ok_reg     <= ack_ok_next;
      timeout_reg    <= timeout_next;
      ack_sample_reg <= ack_sample_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    idx_next        = idx_reg;
    shift_next      = shift_reg;
    parity_next     = parity_reg;
    clk_oe_next     = clk_oe_reg;
    data_oe_next    = data_oe_reg;
    busy_next       = busy_reg;
    done_next       = 1'b0;
    ack_ok_next     = ack_ok_reg;
    timeout_next    = timeout_reg;
    ack_sample_next = ack_sample_reg;

    case (state_reg)
      IDLE: begin
        if (wr) begin
          shift_next   = din;
          parity_next  = odd_parity(din);
          busy_next    = 1'b1;
          cnt_next     = '0;
          idx_next     = '0;
          clk_oe_next  = 1'b1;
          data_oe_next = 1'b0;
          ack_ok_next  = 1'b0;
          timeout_next = 1'b0;
          state_next   = INHIBIT;
        end
      end
      INHIBIT: begin
        if (cnt_reg == CW'(INHIBIT_CYCLES - 1)) begin
          clk_oe_next  = 1'b0;
          data_oe_next = 1'b1;
          cnt_next     = '0;
          state_next   = WAIT_FIRST;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      WAIT_FIRST: begin
        if (fall) begin
          data_oe_next = ~shift_reg[0];
          idx_next     = 4'd1;
          cnt_next     = '0;
          state_next   = DATA;
        end else if (cnt_reg == CW'(START_TIMEOUT - 1)) begin
          clk_oe_next  = 1'b0;
          data_oe_next = 1'b0;
          state_next   = ABORT;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      DATA, PARITY, ACK, WAIT_IDLE: begin
        // One budget covers the whole device-clocked part of the frame.
        if (cnt_reg == CW'(XFER_TIMEOUT - 1)) begin
          clk_oe_next  = 1'b0;
          data_oe_next = 1'b0;
          state_next   = ABORT;
        end else begin
          cnt_next = cnt_reg + 1'b1;
          case (state_reg)
            DATA: if (fall) begin
              if (idx_reg == 4'(DATA_BITS)) begin
                data_oe_next = ~parity_reg;
                state_next   = PARITY;
              end else begin
                data_oe_next = ~shift_reg[idx_reg[2:0]];
                idx_next     = idx_reg + 4'd1;
              end
            end
            PARITY: if (fall) begin
              data_oe_next = 1'b0;
              state_next   = ACK;
            end
            ACK: if (fall) begin
              ack_sample_next = ~sync_data;
              state_next      = WAIT_IDLE;
            end
            default: if (sync_clk && sync_data) begin
              done_next    = 1'b1;
              ack_ok_next  = ack_sample_reg;
              timeout_next = 1'b0;
              busy_next    = 1'b0;
              state_next   = IDLE;
            end
          endcase
        end
      end
      ABORT: begin
        done_next    = 1'b1;
        ack_ok_next  = 1'b0;
        timeout_next = 1'b1;
        busy_next    = 1'b0;
        clk_oe_next  = 1'b0;
        data_oe_next = 1'b0;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign ps2_clk_oe  = clk_oe_reg;
  assign ps2_data_oe = data_oe_reg;
  assign busy        = busy_reg;
  assign rx_inhibit  = busy_reg;
  assign done        = done_reg;
  assign ack_ok      = ack_ok_reg;
  assign timeout     = timeout_reg;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with an open-drain bus and a behavioural
// PS/2 device that clocks frames, samples bits on rising edges and ACKs.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH = 50;
  localparam int ST  = 1000;
  localparam int XT  = 1500;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       wr = 1'b0;
  logic [7:0] din = 8'h00;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       ps2_clk, ps2_data;
  logic       clk_oe, data_oe, busy, done, ack_ok, timeout, rx_inhibit;

  assign ps2_clk  = ~(clk_oe | dev_clk_low);
  assign ps2_data = ~(data_oe | dev_data_low);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .START_TIMEOUT  (ST),
    .XFER_TIMEOUT   (XT),
    .SYNC_STAGES    (2)
  ) dut (
    .clk         (clk),
    .clrn        (clrn),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .ps2_clk_oe  (clk_oe),
    .ps2_data_oe (data_oe),
    .wr          (wr),
    .din         (din),
    .busy        (busy),
    .done        (done),
    .ack_ok      (ack_ok),
    .timeout     (timeout),
    .rx_inhibit  (rx_inhibit)
  );

  int checks = 0;
  int failures = 0;

  // Monitor: records every done pulse and the length of each clock-inhibit run.
  int   done_count = 0;
  logic done_ack, done_to, done_busy, done_prev_busy, done_clk_oe, done_data_oe;
  logic prev_busy = 1'b0;
  int   oe_run = 0;
  int   last_oe_run = 0;

  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_count++;
      done_ack       = ack_ok;
      done_to        = timeout;
      done_busy      = busy;
      done_prev_busy = prev_busy;
      done_clk_oe    = clk_oe;
      done_data_oe   = data_oe;
    end
    prev_busy = busy;
    if (clk_oe === 1'b1) oe_run++;
    else if (oe_run != 0) begin
      last_oe_run = oe_run;
      oe_run = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected device-side samples: 8 data bits LSB first, odd parity, stop.
  function automatic logic [9:0] model_frame(input logic [7:0] b);
    logic [9:0] f;
    for (int i = 0; i < 8; i++) f[i] = ((b >> i) & 8'd1) != 0;
    f[8] = ($countones(b) % 2) == 0;
    f[9] = 1'b1;
    return f;
  endfunction

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    din = b;
    wr  = 1'b1;
    @(negedge clk);
    wr  = 1'b0;
    din = 8'($urandom);
  endtask

  // Start bit is visible once the host releases the clock with data pulled low.
  task automatic wait_start(input string tag);
    bit seen = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (ps2_clk === 1'b1 && data_oe === 1'b1) begin
        seen = 1;
        break;
      end
    end
    check({tag, "_start"}, 32'(seen), 32'd1);
  endtask

  task automatic device(input int half, input bit do_ack, input int stop_fall,
                        output logic [9:0] samp);
    samp = '0;
    for (int f = 1; f <= FALLS_PER_FRAME; f++) begin
      if (f == FALLS_PER_FRAME && do_ack) begin
        repeat (half / 2) @(negedge clk);
        dev_data_low = 1'b1;
        repeat (half - half / 2) @(negedge clk);
      end else begin
        repeat (half) @(negedge clk);
      end
      dev_clk_low = 1'b1;
      if (f == stop_fall) return;
      repeat (half) @(negedge clk);
      if (f <= 10) samp[f-1] = ps2_data;
      dev_clk_low = 1'b0;
    end
    repeat (4) @(negedge clk);
    dev_data_low = 1'b0;
  endtask

  task automatic wait_done(input int prev, input string tag);
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      if (done_count != prev) break;
    end
    check({tag, "_done_seen"}, 32'(done_count != prev), 32'd1);
  endtask

  task automatic xfer(input logic [7:0] b, input int half, input bit do_ack,
                      input bit inject_wr, input string tag);
    logic [9:0] samp;
    int dc;
    dc = done_count;
    send(b);
    check({tag, "_busy"}, {30'd0, busy, rx_inhibit}, 32'd3);
    if (inject_wr) begin
      repeat (10) @(negedge clk);
      din = 8'h55;
      wr  = 1'b1;
      @(negedge clk);
      wr  = 1'b0;
    end
    wait_start(tag);
    device(half, do_ack, 0, samp);
    wait_done(dc, tag);
    repeat (60) @(posedge clk);
    check({tag, "_samples"}, 32'(samp), 32'(model_frame(b)));
    check({tag, "_inhibit_len"}, 32'(last_oe_run), 32'(INH));
    check({tag, "_ack_to"}, {30'd0, done_ack, done_to}, {30'd0, do_ack, 1'b0});
    check({tag, "_busy_edge"}, {30'd0, done_prev_busy, done_busy}, 32'd2);
    check({tag, "_one_done"}, 32'(done_count - dc), 32'd1);
    $display("xfer %s byte=%02h half=%0d samples=%03h ack_ok=%0b timeout=%0b",
             tag, b, half, samp, done_ack, done_to);
  endtask

  initial begin
    logic [9:0] samp;
    int n;
    int dc;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {25'd0, clk_oe, data_oe, busy, done, ack_ok, timeout, rx_inhibit}, 32'd0);
    clrn = 1'b1;
    repeat (5) @(negedge clk);

    xfer(CMD_SET_LEDS, 20, 1, 0, "cmd_ed");
    check("ack_held", {30'd0, ack_ok, timeout}, 32'd2);

    xfer(8'h00, 20, 1, 0, "byte_00");
    xfer(8'h01, 20, 1, 0, "byte_01");
    for (int k = 0; k < 3; k++) xfer(8'($urandom), int'($urandom_range(12, 24)), 1, 0, "rand");

    // Device never clocks: WAIT_FIRST spans START_TIMEOUT cycles, one ABORT
    // cycle follows with both lines released, then done is visible.
    dc = done_count;
    send(CMD_ECHO);
    wait_start("no_clock");
    n = 0;
    for (int i = 0; i < ST + 100; i++) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) break;
    end
    check("no_clock_latency", 32'(n), 32'(ST + 1));
    @(posedge clk);
    check("no_clock_ack_to", {30'd0, done_ack, done_to}, 32'd1);
    check("no_clock_oe", {30'd0, done_clk_oe, done_data_oe}, 32'd0);
    check("no_clock_one_done", 32'(done_count - dc), 32'd1);
    $display("xfer no_clock byte=%02h latency=%0d timeout=%0b", CMD_ECHO, n, done_to);
    check("timeout_held", {30'd0, ack_ok, timeout}, 32'd1);

    xfer(8'($urandom), 18, 0, 0, "no_ack");

    xfer(8'hF3, 20, 1, 1, "wr_while_busy");
    dc = done_count;
    repeat (200) @(posedge clk);
    check("wr_while_busy_idle", {31'd0, busy}, 32'd0);
    check("wr_while_busy_no_extra", 32'(done_count - dc), 32'd0);

    // Reset mid-frame at the fifth device fall.
    send(8'($urandom));
    wait_start("reset_mid");
    device(20, 0, 5, samp);
    dc = done_count;
    #3 clrn = 1'b0;
    #1;
    check("reset_mid_async", {29'd0, clk_oe, data_oe, busy, rx_inhibit}, 32'd0);
    dev_clk_low = 1'b0;
    repeat (3) @(negedge clk);
    clrn = 1'b1;
    repeat (200) @(posedge clk);
    check("reset_mid_no_done", 32'(done_count - dc), 32'd0);
    $display("xfer reset_mid aborted at fall 5 dones_after=%0d", done_count - dc);

    xfer(CMD_RESET, 20, 1, 0, "cmd_ff");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
